// File: rtl/mbc_pkg.sv
// Shared definitions for the MBC-family cartridge mappers: size masks, RTC register
// indices and field widths, and the RTC latch sequencer states.
package mbc_pkg;

    localparam logic [3:0] RTC_S  = 4'h8;
    localparam logic [3:0] RTC_M  = 4'h9;
    localparam logic [3:0] RTC_H  = 4'hA;
    localparam logic [3:0] RTC_DL = 4'hB;
    localparam logic [3:0] RTC_DH = 4'hC;

    localparam int RTC_SEC_W  = 6;
    localparam int RTC_MIN_W  = 6;
    localparam int RTC_HOUR_W = 5;
    localparam int RTC_DAY_W  = 9;

    typedef logic [0:0] latch_state_t;
    localparam latch_state_t LATCH_IDLE  = 1'b0;
    localparam latch_state_t LATCH_ARMED = 1'b1;

    // Header byte 0x148: 0 is 32 kB, each step doubles, 7 is 4 MB.
    function automatic logic [21:0] rom_mask(input logic [2:0] rom_size);
        return 22'((32'h0000_8000 << rom_size) - 32'd1);
    endfunction

    // Header byte 0x149: 0 means no RAM, so the whole window masks to zero.
    function automatic logic [16:0] ram_mask(input logic [2:0] ram_size);
        logic [16:0] mask;
        case (ram_size)
            3'd1:    mask = 17'h007FF;
            3'd2:    mask = 17'h01FFF;
            3'd3:    mask = 17'h07FFF;
            3'd4:    mask = 17'h1FFFF;
            3'd5:    mask = 17'h0FFFF;
            default: mask = 17'h00000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mbc_rtc.sv
// MBC3 real-time clock: prescaler, live S/M/H/day counters, latched copy and the
// 0x00-then-0x01 latch sequencer.
module mbc_rtc
    import mbc_pkg::*;
#(
    parameter int TICK_DIV = 32768
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rtc_clk_en,
    input  logic       reg_wr,
    input  logic       latch_wr,
    input  logic [3:0] reg_idx,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]      prescaler;
    logic                  tick;

    logic [RTC_SEC_W-1:0]  sec,   sec_n,   sec_l;
    logic [RTC_MIN_W-1:0]  min,   min_n,   min_l;
    logic [RTC_HOUR_W-1:0] hour,  hour_n,  hour_l;
    logic [RTC_DAY_W-1:0]  day,   day_n,   day_l;
    logic                  halt,  halt_n,  halt_l;
    logic                  carry, carry_n, carry_l;

    latch_state_t          latch_state;
    logic                  do_latch;

    assign tick = rtc_clk_en && !halt && (prescaler == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (reg_wr && (reg_idx == RTC_S)) begin
            prescaler <= '0;
        end else if (rtc_clk_en && !halt) begin
            prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PRE_W'(1);
        end
    end

    // The tick result is computed first so a CPU write overrides only its own field.
    always_comb begin
        sec_n   = sec;
        min_n   = min;
        hour_n  = hour;
        day_n   = day;
        halt_n  = halt;
        carry_n = carry;
        if (tick) begin
            if (sec == RTC_SEC_W'(59)) begin
                sec_n = '0;
                if (min == RTC_MIN_W'(59)) begin
                    min_n = '0;
                    if (hour == RTC_HOUR_W'(23)) begin
                        hour_n = '0;
                        if (day == RTC_DAY_W'(511)) begin
                            day_n   = '0;
                            carry_n = 1'b1;
                        end else begin
                            day_n = day + RTC_DAY_W'(1);
                        end
                    end else begin
                        hour_n = hour + RTC_HOUR_W'(1);
                    end
                end else begin
                    min_n = min + RTC_MIN_W'(1);
                end
            end else begin
                sec_n = sec + RTC_SEC_W'(1);
            end
        end
        if (reg_wr) begin
            case (reg_idx)
                RTC_S:  sec_n       = wr_data[RTC_SEC_W-1:0];
                RTC_M:  min_n       = wr_data[RTC_MIN_W-1:0];
                RTC_H:  hour_n      = wr_data[RTC_HOUR_W-1:0];
                RTC_DL: day_n[7:0]  = wr_data;
                RTC_DH: begin
                    day_n[8] = wr_data[0];
                    halt_n   = wr_data[6];
                    carry_n  = wr_data[7];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec   <= '0;
            min   <= '0;
            hour  <= '0;
            day   <= '0;
            halt  <= 1'b0;
            carry <= 1'b0;
        end else begin
            sec   <= sec_n;
            min   <= min_n;
            hour  <= hour_n;
            day   <= day_n;
            halt  <= halt_n;
            carry <= carry_n;
        end
    end

    assign do_latch = latch_wr && (latch_state == LATCH_ARMED) && (wr_data == 8'h01);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch_state <= LATCH_IDLE;
        end else if (latch_wr) begin
            case (latch_state)
                LATCH_IDLE:  latch_state <= (wr_data == 8'h00) ? LATCH_ARMED : LATCH_IDLE;
                default:     latch_state <= LATCH_IDLE;
            endcase
        end
    end

    // The copy samples the current registers, so a coincident tick is not visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_l   <= '0;
            min_l   <= '0;
            hour_l  <= '0;
            day_l   <= '0;
            halt_l  <= 1'b0;
            carry_l <= 1'b0;
        end else if (do_latch) begin
            sec_l   <= sec;
            min_l   <= min;
            hour_l  <= hour;
            day_l   <= day;
            halt_l  <= halt;
            carry_l <= carry;
        end
    end

    always_comb begin
        case (reg_idx)
            RTC_S:   rd_data = {2'b11, sec_l};
            RTC_M:   rd_data = {2'b11, min_l};
            RTC_H:   rd_data = {3'b111, hour_l};
            RTC_DL:  rd_data = day_l[7:0];
            RTC_DH:  rd_data = {carry_l, halt_l, 5'b11111, day_l[8]};
            default: rd_data = 8'hFF;
        endcase
    end

endmodule

// File: rtl/mbc3_chip.sv
// MBC3-class cartridge mapper: ROM/RAM banking plus an optional latched RTC,
// built only when MBC3_RTC_EN is defined.
module mbc3_chip
    import mbc_pkg::*;
#(
    parameter int ROM_BANK_BITS = 7,
    parameter int RAM_BANK_BITS = 2,
    parameter int TICK_DIV      = 32768
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ics_rom,
    input  logic                        ics_ram,
    input  logic [14:0]                 iadr,
    input  logic [7:0]                  data,
    input  logic                        write,
    input  logic                        rtc_clk_en,
    output logic [14+ROM_BANK_BITS-1:0] oadr,
    output logic                        sel_rom,
    output logic                        sel_ram,
    output logic [7:0]                  rdata,
    output logic                        rdata_oe,
    input  logic [2:0]                  rom_size,
    input  logic [2:0]                  ram_size
);

    localparam int OADR_W    = 14 + ROM_BANK_BITS;
    localparam int RAM_ADR_W = 13 + RAM_BANK_BITS;

    logic                     pwrite;
    logic                     commit;
    logic                     rom_wr;
    logic                     ena_ram;
    logic [ROM_BANK_BITS-1:0] rom_bank;
    logic [ROM_BANK_BITS-1:0] rom_bank_eff;
    logic [3:0]               ram_sel;
    logic                     ram_window;
    logic                     ram_mapped;
    logic [21:0]              rom_mask_full;
    logic [16:0]              ram_mask_full;
    logic [OADR_W-1:0]        rom_raw;
    logic [OADR_W-1:0]        rom_addr;
    logic [RAM_ADR_W-1:0]     ram_addr;
    logic                     unused_mask;

    assign commit = pwrite && !write;
    assign rom_wr = commit && ics_rom;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwrite <= 1'b0;
        end else begin
            pwrite <= write;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ena_ram  <= 1'b0;
            rom_bank <= ROM_BANK_BITS'(1);
            ram_sel  <= 4'h0;
        end else if (rom_wr) begin
            case (iadr[14:13])
                2'b00:   ena_ram  <= (data[3:0] == 4'hA);
                2'b01:   rom_bank <= data[ROM_BANK_BITS-1:0];
                2'b10:   ram_sel  <= data[3:0];
                default: ;
            endcase
        end
    end

    // Only bank 0 is remapped; 0x20/0x40/0x60 stay reachable unlike MBC1.
    assign rom_bank_eff  = (rom_bank == '0) ? ROM_BANK_BITS'(1) : rom_bank;
    assign ram_window    = ics_ram && (iadr[14:13] == 2'b01);
    assign ram_mapped    = (32'(ram_sel) < (32'd1 << RAM_BANK_BITS));
    assign rom_mask_full = rom_mask(rom_size);
    assign ram_mask_full = ram_mask(ram_size);
    assign unused_mask   = ^{rom_mask_full, ram_mask_full};

    always_comb begin
        rom_raw  = iadr[14] ? {rom_bank_eff, iadr[13:0]}
                            : {{ROM_BANK_BITS{1'b0}}, iadr[13:0]};
        rom_addr = rom_raw & rom_mask_full[OADR_W-1:0];
        ram_addr = {ram_sel[RAM_BANK_BITS-1:0], iadr[12:0]} & ram_mask_full[RAM_ADR_W-1:0];
        oadr     = ram_window ? OADR_W'(ram_addr) : rom_addr;
    end

    assign sel_rom = reset_n && ics_rom;
    assign sel_ram = reset_n && ram_window && ram_mapped && ena_ram && (ram_size != 3'd0);

`ifdef MBC3_RTC_EN
    logic       rtc_sel;
    logic       rtc_access;
    logic       rtc_reg_wr;
    logic       rtc_latch_wr;
    logic [7:0] rtc_rdata;

    assign rtc_sel      = (ram_sel >= RTC_S) && (ram_sel <= RTC_DH);
    assign rtc_access   = ram_window && !ram_mapped && rtc_sel;
    assign rtc_reg_wr   = commit && rtc_access && ena_ram;
    assign rtc_latch_wr = rom_wr && (iadr[14:13] == 2'b11);

    mbc_rtc #(
        .TICK_DIV (TICK_DIV)
    ) u_rtc (
        .clk        (clk),
        .reset_n    (reset_n),
        .rtc_clk_en (rtc_clk_en),
        .reg_wr     (rtc_reg_wr),
        .latch_wr   (rtc_latch_wr),
        .reg_idx    (ram_sel),
        .wr_data    (data),
        .rd_data    (rtc_rdata)
    );

    assign rdata    = (reset_n && rtc_access) ? rtc_rdata : 8'hFF;
    assign rdata_oe = reset_n && rtc_access && ena_ram && !write;
`else
    logic unused_rtc;

    assign unused_rtc = ^{rtc_clk_en, data};
    assign rdata      = 8'hFF;
    assign rdata_oe   = 1'b0;
`endif

endmodule

// File: tb/tb_mbc3_chip.sv
// Randomized bench for mbc3_chip against an integer-arithmetic cartridge model;
// RTC checks are active when MBC3_RTC_EN is defined.
module tb_mbc3_chip;

    localparam int RBB    = 7;
    localparam int RAMB   = 2;
    localparam int TD     = 8;
    localparam int OADR_W = 14 + RBB;
`ifdef MBC3_RTC_EN
    localparam bit RTC_EN = 1'b1;
`else
    localparam bit RTC_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ics_rom, ics_ram, write, rtc_clk_en;
    logic [14:0]       iadr;
    logic [7:0]        data;
    logic [OADR_W-1:0] oadr;
    logic              sel_rom, sel_ram, rdata_oe;
    logic [7:0]        rdata;
    logic [2:0]        rom_size, ram_size;

    mbc3_chip #(
        .ROM_BANK_BITS (RBB),
        .RAM_BANK_BITS (RAMB),
        .TICK_DIV      (TD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ics_rom    (ics_rom),
        .ics_ram    (ics_ram),
        .iadr       (iadr),
        .data       (data),
        .write      (write),
        .rtc_clk_en (rtc_clk_en),
        .oadr       (oadr),
        .sel_rom    (sel_rom),
        .sel_ram    (sel_ram),
        .rdata      (rdata),
        .rdata_oe   (rdata_oe),
        .rom_size   (rom_size),
        .ram_size   (ram_size)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Cartridge model: plain integers, one per architectural quantity.
    int m_bank, m_ram_sel, m_pre;
    bit m_ena, m_armed;
    int live_s, live_m, live_h, live_d;
    bit live_halt, live_carry;
    int lat_s, lat_m, lat_h, lat_d;
    bit lat_halt, lat_carry;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_bank = 1; m_ram_sel = 0; m_pre = 0; m_ena = 0; m_armed = 0;
        live_s = 0; live_m = 0; live_h = 0; live_d = 0; live_halt = 0; live_carry = 0;
        lat_s = 0; lat_m = 0; lat_h = 0; lat_d = 0; lat_halt = 0; lat_carry = 0;
    endtask

    task automatic modelSecond();
        if (live_s != 59) begin live_s = (live_s + 1) % 64; return; end
        live_s = 0;
        if (live_m != 59) begin live_m = (live_m + 1) % 64; return; end
        live_m = 0;
        if (live_h != 23) begin live_h = (live_h + 1) % 32; return; end
        live_h = 0;
        if (live_d != 511) begin live_d = live_d + 1; return; end
        live_d = 0;
        live_carry = 1;
    endtask

    task automatic modelPulse();
        if (!RTC_EN || live_halt) return;
        m_pre++;
        if (m_pre == TD) begin
            m_pre = 0;
            modelSecond();
        end
    endtask

    task automatic modelCommit(input int addr, input int v, input bit tick);
        if (addr < 'h8000 && addr >= 'h6000 && RTC_EN) begin
            if (!m_armed) begin
                m_armed = (v == 0);
            end else begin
                m_armed = 0;
                if (v == 1) begin
                    lat_s = live_s; lat_m = live_m; lat_h = live_h; lat_d = live_d;
                    lat_halt = live_halt; lat_carry = live_carry;
                end
            end
        end
        if (tick) modelPulse();
        if (addr < 'h2000) m_ena = ((v % 16) == 10);
        else if (addr < 'h4000) m_bank = v % 128;
        else if (addr < 'h6000) m_ram_sel = v % 16;
        else if (addr >= 'hA000 && addr <= 'hBFFF && RTC_EN && m_ena && m_ram_sel >= 8 && m_ram_sel <= 12) begin
            case (m_ram_sel)
                8:  begin live_s = v % 64; m_pre = 0; end
                9:  live_m = v % 64;
                10: live_h = v % 32;
                11: live_d = (live_d / 256) * 256 + v;
                default: begin
                    live_d     = (live_d % 256) + (v % 2) * 256;
                    live_halt  = (v / 64) % 2;
                    live_carry = v / 128;
                end
            endcase
        end
    endtask

    function automatic int latchedByte(input int idx);
        case (idx)
            8:  return 'hC0 + lat_s;
            9:  return 'hC0 + lat_m;
            10: return 'hE0 + lat_h;
            11: return lat_d % 256;
            default: return lat_carry * 128 + lat_halt * 64 + 'h3E + lat_d / 256;
        endcase
    endfunction

    function automatic int ramBytes(input int sz);
        case (sz)
            1: return 2048;
            2: return 8192;
            3: return 32768;
            4: return 131072;
            5: return 65536;
            default: return 0;
        endcase
    endfunction

    task automatic driveAddr(input int addr);
        iadr    = 15'(addr);
        ics_rom = (addr < 'h8000);
        ics_ram = (addr >= 'hA000 && addr <= 'hBFFF);
    endtask

    task automatic applyStimulus(input int addr, input int v, input bit tick);
        driveAddr(addr);
        data  = 8'(v);
        write = 1'b1;
        @(posedge clk); #1;
        write      = 1'b0;
        rtc_clk_en = tick;
        @(posedge clk); #1;
        rtc_clk_en = 1'b0;
        modelCommit(addr, v, tick);
    endtask

    task automatic pulseTicks(input int n, input bit sparse);
        for (int k = 0; k < n; k++) begin
            rtc_clk_en = sparse ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (rtc_clk_en) modelPulse();
            rtc_clk_en = 1'b0;
        end
    endtask

    task automatic latchNow();
        applyStimulus('h6000, 'h00, 1'b0);
        applyStimulus('h6000, 'h01, 1'b0);
    endtask

    task automatic checkRead(input int addr, input string tag);
        int  exp_adr, size;
        bit  rtc_reg;
        driveAddr(addr);
        write = 1'b0;
        #1;
        if (addr < 'h8000) begin
            exp_adr = (addr < 'h4000) ? addr : ((m_bank == 0) ? 1 : m_bank) * 'h4000 + (addr - 'h4000);
            exp_adr = exp_adr % (32'h8000 << rom_size);
            exp_adr = exp_adr % (1 << OADR_W);
            checkOutput({tag, "/sel_rom"}, 32'(sel_rom), 1);
            checkOutput({tag, "/sel_ram"}, 32'(sel_ram), 0);
            checkOutput({tag, "/oadr"}, 32'(oadr), exp_adr);
            checkOutput({tag, "/rdata_oe"}, 32'(rdata_oe), 0);
        end else begin
            checkOutput({tag, "/sel_rom"}, 32'(sel_rom), 0);
            if (m_ram_sel < (1 << RAMB)) begin
                size    = ramBytes(int'(ram_size));
                exp_adr = m_ram_sel * 'h2000 + (addr % 'h2000);
                exp_adr = (size == 0) ? 0 : exp_adr % size;
                checkOutput({tag, "/sel_ram"}, 32'(sel_ram), 32'(m_ena && ram_size != 0));
                checkOutput({tag, "/oadr"}, 32'(oadr), exp_adr);
                checkOutput({tag, "/rdata_oe"}, 32'(rdata_oe), 0);
            end else begin
                rtc_reg = RTC_EN && m_ram_sel >= 8 && m_ram_sel <= 12;
                checkOutput({tag, "/sel_ram"}, 32'(sel_ram), 0);
                checkOutput({tag, "/rdata_oe"}, 32'(rdata_oe), 32'(rtc_reg && m_ena));
                if (rtc_reg && m_ena) checkOutput({tag, "/rdata"}, 32'(rdata), latchedByte(m_ram_sel));
            end
        end
    endtask

    initial begin
        int act, v;
        reset_n = 1'b0; ics_rom = 1'b1; ics_ram = 1'b0; write = 1'b0; rtc_clk_en = 1'b0;
        iadr = 15'h4000; data = 8'h00; rom_size = 3'd7; ram_size = 3'd3;
        modelReset();
        #1;
        checkOutput("reset/sel_rom", 32'(sel_rom), 0);
        checkOutput("reset/sel_ram", 32'(sel_ram), 0);
        checkOutput("reset/rdata_oe", 32'(rdata_oe), 0);
        checkOutput("reset/rdata", 32'(rdata), 'hFF);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        checkRead('h4000, "boot_bank");
        checkRead('h0123, "boot_low");

        applyStimulus('h2000, 'h00, 1'b0);
        checkRead('h4000, "bank0");
        checkOutput("bank0_is_1", 32'(oadr), 'h04000);
        applyStimulus('h2000, 'h20, 1'b0);
        checkRead('h4000, "bank20");
        checkOutput("bank20_const", 32'(oadr), 'h80000);

        applyStimulus('h0000, 'h0A, 1'b0);
        applyStimulus('h4000, 'h03, 1'b0);
        checkRead('hA123, "ram_b3");
        checkOutput("ram_b3_sel", 32'(sel_ram), 1);
        checkOutput("ram_b3_adr", 32'(oadr), 'h6123);
        applyStimulus('h0000, 'h00, 1'b0);
        checkRead('hA123, "ram_off");
        checkOutput("ram_off_sel", 32'(sel_ram), 0);

`ifdef MBC3_RTC_EN
        applyStimulus('h0000, 'h0A, 1'b0);
        for (int r = 8; r <= 12; r++) begin
            applyStimulus('h4000, r, 1'b0);
            applyStimulus('hA000, (r == 8) ? 59 : (r == 9) ? 59 : (r == 10) ? 23 : (r == 11) ? 'hFF : 'h01, 1'b0);
        end
        pulseTicks(TD, 1'b0);
        latchNow();
        for (int r = 8; r <= 12; r++) begin
            applyStimulus('h4000, r, 1'b0);
            checkRead('hA000, $sformatf("rollover_r%0d", r));
        end
        checkOutput("rollover_dh", 32'(rdata & 8'hC1), 'h80);

        applyStimulus('h4000, 8, 1'b0);
        applyStimulus('hA000, 5, 1'b0);
        applyStimulus('h6000, 'h01, 1'b0);
        checkRead('hA000, "latch_01_alone");
        checkOutput("latch_01_alone_s", 32'(rdata & 8'h3F), 0);
        applyStimulus('h6000, 'h00, 1'b0);
        applyStimulus('h6000, 'h05, 1'b0);
        applyStimulus('h6000, 'h01, 1'b0);
        checkRead('hA000, "latch_broken");
        checkOutput("latch_broken_s", 32'(rdata & 8'h3F), 0);
        latchNow();
        checkRead('hA000, "latch_ok");
        checkOutput("latch_ok_s", 32'(rdata & 8'h3F), 5);

        pulseTicks(TD - 1, 1'b0);
        applyStimulus('hA000, 10, 1'b1);
        latchNow();
        checkRead('hA000, "wr_vs_tick");
        checkOutput("wr_vs_tick_s", 32'(rdata & 8'h3F), 10);
        pulseTicks(TD - 1, 1'b0);
        latchNow();
        checkOutput("pre_cleared_s", 32'(rdata & 8'h3F), 10);
        pulseTicks(1, 1'b0);
        latchNow();
        checkOutput("next_second_s", 32'(rdata & 8'h3F), 11);

        applyStimulus('h4000, 12, 1'b0);
        applyStimulus('hA000, 'h40, 1'b0);
        pulseTicks(3 * TD, 1'b0);
        latchNow();
        applyStimulus('h4000, 8, 1'b0);
        checkRead('hA000, "halted");
        checkOutput("halted_s", 32'(rdata & 8'h3F), 11);
        applyStimulus('h4000, 12, 1'b0);
        applyStimulus('hA000, 'h00, 1'b0);
        pulseTicks(TD - 1 - m_pre, 1'b0);
        applyStimulus('h6000, 'h00, 1'b0);
        applyStimulus('h6000, 'h01, 1'b1);
        applyStimulus('h4000, 8, 1'b0);
        checkRead('hA000, "latch_vs_tick");
`else
        applyStimulus('h0000, 'h0A, 1'b0);
        applyStimulus('h4000, 8, 1'b0);
        applyStimulus('hA000, 'h21, 1'b0);
        applyStimulus('h6000, 'h00, 1'b0);
        applyStimulus('h6000, 'h01, 1'b0);
        checkRead('hA000, "no_rtc");
        checkOutput("no_rtc_oe", 32'(rdata_oe), 0);
`endif

        for (int i = 0; i < 300; i++) begin
            act = $urandom_range(0, 9);
            case (act)
                0: applyStimulus('h2000 + $urandom_range(0, 'h1FFF), $urandom_range(0, 255), 1'($urandom_range(0, 3) == 0));
                1: applyStimulus($urandom_range(0, 'h1FFF), ($urandom_range(0, 1) == 1) ? 'h0A : $urandom_range(0, 255), 1'b0);
                2: applyStimulus('h4000 + $urandom_range(0, 'h1FFF), $urandom_range(0, 15), 1'b0);
                3: begin
                    v = $urandom_range(0, 2);
                    applyStimulus('h6000, 'h00, 1'b0);
                    applyStimulus('h6000 + $urandom_range(0, 'h1FFF), (v == 2) ? $urandom_range(0, 255) : 1, 1'($urandom_range(0, 3) == 0));
                end
                4: begin
                    applyStimulus('h4000, $urandom_range(8, 12), 1'b0);
                    applyStimulus('hA000 + $urandom_range(0, 'h1FFF), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
                end
                5: pulseTicks($urandom_range(1, 20), 1'b1);
                default: begin
                    rom_size = 3'($urandom_range(0, 7));
                    ram_size = 3'($urandom_range(0, 5));
                    v = $urandom_range(0, 2);
                    checkRead((v == 0) ? $urandom_range(0, 'h3FFF) : (v == 1) ? $urandom_range('h4000, 'h7FFF) : $urandom_range('hA000, 'hBFFF),
                              $sformatf("rnd%0d", i));
                end
            endcase
        end

        rom_size = 3'd7;
        driveAddr('h2000);
        data  = 8'h05;
        write = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid/sel_rom", 32'(sel_rom), 0);
        checkOutput("rst_mid/sel_ram", 32'(sel_ram), 0);
        checkOutput("rst_mid/rdata", 32'(rdata), 'hFF);
        write = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        modelReset();
        @(posedge clk); @(posedge clk); #1;
        checkRead('h4000, "rst_after");
        checkOutput("rst_after_bank1", 32'(oadr), 'h04000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mbc3_chip.md
# mbc3_chip

Parametrised MBC3-class cartridge mapper: the next generation of the team's MBC1 mapper. It sits between the Game Boy cartridge bus and the ROM/RAM backing store. It adds a wider ROM bank register with no mode bit, more RAM banks, and a latched real-time clock (RTC) readable through the RAM window. All register writes are taken on the falling edge of `write`, the same as the existing mapper.

## Interface
- `ROM_BANK_BITS`, default 7: ROM bank register width. 7 gives 2 MB; 8 gives 4 MB (MBC30).
- `RAM_BANK_BITS`, default 2: RAM bank index width. 2 gives 32 kB; 3 gives 64 kB.
- `TICK_DIV`, default 32768: number of `rtc_clk_en` pulses per RTC second.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ics_rom` in 1: cartridge ROM chip select (0x0000-0x7fff).
- `ics_ram` in 1: cartridge RAM chip select (0xa000-0xbfff).
- `iadr` in 15: CPU address A14..A0.
- `data` in 8: CPU write data.
- `write` in 1: CPU write strobe; the write commits on its falling edge.
- `rtc_clk_en` in 1: single-cycle enable, nominally 32.768 kHz, already synchronous to `clk`.
- `oadr` out 14+`ROM_BANK_BITS`: backing-store address, masked by size.
- `sel_rom` out 1: ROM access select.
- `sel_ram` out 1: RAM access select.
- `rdata` out 8: RTC read data.
- `rdata_oe` out 1: `rdata` drives the bus.
- `rom_size` in 3: cartridge header byte 0x148.
- `ram_size` in 3: cartridge header byte 0x149.

## Operation
- **Write detection**: `pwrite` is `write` delayed by one cycle. A register commit happens when `pwrite && !write`.
- **ROM-side writes** (`ics_rom` set), decoded on `iadr[14:13]`:
  - 00: `ena_ram <= (data[3:0]==4'hA)`.
  - 01: `rom_bank <= data[ROM_BANK_BITS-1:0]`. A stored 0 is used as bank 1. Unlike MBC1, 0x20/0x40/0x60 are reachable.
  - 10: `ram_sel <= data[3:0]`.
  - 11: latch sequencer (see RTC).
- **ROM window**:
  - `iadr[14]==0`: `oadr = iadr[13:0]`.
  - `iadr[14]==1`: `oadr = {rom_bank_eff, iadr[13:0]}`.
  - Both are ANDed with the `rom_size` mask (0x00 = 32 kB … 0x07 = 4 MB).
- **RAM window** (`ics_ram` set, `iadr[14:13]==01`):
  - `ram_sel < 2**RAM_BANK_BITS`: `oadr[14+RAM_BANK_BITS-2:0] = {ram_sel, iadr[12:0]}`, masked by `ram_size`. `sel_ram = ena_ram & |ram_size`.
  - `ram_sel` in 0x08..0x0C: RTC register access. `sel_ram=0`. `rdata_oe = ena_ram & !write`.
  - Any other `ram_sel` value: unmapped. `sel_ram=0`, `rdata_oe=0`.
- **RTC registers** (S, M, H, DL, DH):
  - S: 6 bits. M: 6 bits. H: 5 bits. DL: day[7:0].
  - DH: bit0 = day[8], bit6 = halt, bit7 = carry.
  - Unused bits read 1.
- **Counting**: the prescaler counts `rtc_clk_en` pulses while halt is clear. It wraps at `TICK_DIV-1` and emits a second tick.
  - On a tick: S==59 → S=0 and M increments. Otherwise S = (S+1) mod 64, with no carry.
  - M follows the same rule.
  - H==23 → H=0 and day increments. Otherwise H = (H+1) mod 32.
  - day==511 → day=0 and carry=1. Carry is sticky and is cleared only by writing DH.
- **RTC write**: a commit with `ics_ram` set, RAM window, `ena_ram`, and `ram_sel` in 0x08..0x0C writes the live register. Writing S also clears the prescaler.
- **RTC read**: `rdata` returns the latched copy, never the live counters.
- **Latch FSM**:
  - Two states, IDLE and ARMED.
  - Writing 0x00 moves to ARMED.
  - In ARMED, writing 0x01 copies live → latched and returns to IDLE.
  - In ARMED, any other value returns to IDLE.
  - In IDLE, writing 0x01 does nothing.
- **Reset values**: `rom_bank=1`, `ram_sel=0`, `ena_ram=0`, `pwrite=0`, latch FSM IDLE, prescaler 0. Live and latched RTC registers are all 0.
- **Outputs while `reset_n==0`**: `sel_rom=0`, `sel_ram=0`, `rdata_oe=0`, `rdata=8'hFF`. `oadr` is don't-care.

## Timing
- All register commits occur at the clock edge where `pwrite && !write`.
- The new mapping appears combinationally on `oadr`, `sel_*` and `rdata` right after that edge. Address-to-`oadr` latency is zero cycles.
- Tick and CPU write to the same RTC register in the same cycle: the write wins and the increment is discarded.
- A write to a different register in the same cycle as a tick: the tick still applies, including its carries.
- Latch and tick in the same cycle: the latched copy holds the pre-increment value.
- Halt set mid-second: the prescaler freezes. Clearing halt resumes counting from the frozen prescaler value.
- Reset asserted mid-write: the commit is lost, and `pwrite=0` prevents a spurious commit after release.

## Configuration
- `MBC3_RTC_EN` defined: the RTC, prescaler and latch FSM are built as described above.
- Not defined:
  - No RTC logic is built.
  - `ram_sel` 0x08..0x0C behaves as unmapped.
  - Writes to 0x6000-0x7fff are ignored.
  - `rtc_clk_en` is unused.
  - `rdata_oe` is tied to 0.
  - ROM and RAM banking are unchanged.

## Structure
- Package `mbc_pkg` holds:
  - the ROM and RAM size-to-mask functions, shared with the MBC1 mapper;
  - RTC register index constants (`RTC_S`=8 … `RTC_DH`=12);
  - RTC field widths;
  - latch FSM state enum.
- Sub-module `mbc_rtc`: prescaler, live and latched counters, and latch FSM. It is instantiated only under `MBC3_RTC_EN`.

## Test plan
- **ROM banking**: write 0x00 to 0x2000 → `oadr` for 0x4000 is 0x04000. Write 0x20 → 0x80000.
- **RAM enable and bank**: write 0x0A to 0x0000, then 0x03 to 0x4000; access 0xA123 → `sel_ram=1`, `oadr=0x6123` (32 kB RAM). Write 0x00 to 0x0000 → `sel_ram=0`.
- **Full RTC rollover**: set S=59, M=59, H=23, day=511, halt=0; pulse `TICK_DIV` times; latch → all zero, DH=0x80.
- **Latch sequence**:
  - 0x00 then 0x01 latches.
  - 0x01 alone does not.
  - 0x00, 0x05, 0x01 does not latch.
  - Read 0x08 → `rdata` holds the old value until a valid latch.
- **Simultaneous events**: write S=10 in the same cycle as a second tick → S=10 and the prescaler is 0. Halt=1 → no change after 3×`TICK_DIV` pulses.
- **Reset**: drop `reset_n` mid-write → `sel_*=0` immediately. After release, `rom_bank=1` and no commit from the interrupted strobe.
